// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA stream arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package dma_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    localparam int DMA_DATA_WIDTH = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request after i_last wins.
// Rotation through a doubled vector handles non-power-of-two N.
module rr_pick
    import dma_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last,
    output logic           o_any,
    output logic [IDW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    assign w_dbl = {i_req, i_req} >> (int'(i_last) + 1);
    assign w_rot = w_dbl[N-1:0];

    // Lowest rotated bit is closest after i_last; scan down so it wins.
    always_comb begin
        o_any = |w_rot;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx = IDW'((int'(i_last) + 1 + k) % N);
            end
        end
    end

endmodule

// File: rtl/dma_stream_arbiter.sv
// Packet-granular round-robin arbiter onto one AXI4-Stream channel.
// Grant held from first beat to last; output through a one-entry register.
module dma_stream_arbiter
    import dma_pkg::*;
#(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int  CNT_WIDTH  = 16,
    localparam int IDW        = clog2_min1(NUM_SRC)
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset_n,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]            s_axis_last,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic                          m_axis_valid,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    output logic                          m_axis_last,
    input  logic                          m_axis_ready,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    state_t                r_state;
    logic [IDW-1:0]        r_rr_last;
    logic [IDW-1:0]        r_gid;
    logic                  r_gvalid;
    logic                  r_mvalid;
    logic                  r_mlast;
    logic [DATA_WIDTH-1:0] r_mdata;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_out_free;
    logic                  w_any;
    logic [IDW-1:0]        w_win;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;

    rr_pick #(
        .N   (NUM_SRC),
        .IDW (IDW)
    ) u_pick (
        .i_req  (s_axis_valid),
        .i_last (r_rr_last),
        .o_any  (w_any),
        .o_idx  (w_win)
    );

    assign w_out_free  = !r_mvalid || m_axis_ready;
    assign w_sel_valid = s_axis_valid[r_gid];
    assign w_sel_last  = s_axis_last[r_gid];
    assign w_sel_data  = s_axis_data[int'(r_gid)*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept    = (r_state == ST_XFER) && w_sel_valid && w_out_free;

    // Only the granted source sees ready, and only when the output can take a beat.
    always_comb begin
        s_axis_ready = '0;
        if (r_state == ST_XFER) begin
            s_axis_ready[r_gid] = w_out_free;
        end
    end

    // Arbitration FSM, output pipeline register and packet counter.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state   <= ST_IDLE;
            r_rr_last <= IDW'(NUM_SRC - 1);
            r_gid     <= '0;
            r_gvalid  <= 1'b0;
            r_mvalid  <= 1'b0;
            r_mlast   <= 1'b0;
            r_mdata   <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_mvalid <= 1'b1;
                r_mdata  <= w_sel_data;
                r_mlast  <= w_sel_last;
            end else if (m_axis_ready) begin
                r_mvalid <= 1'b0;
                r_mlast  <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gid    <= w_win;
                        r_gvalid <= 1'b1;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept && w_sel_last) begin
                        r_rr_last <= r_gid;
                        r_cnt     <= r_cnt + 1'b1;
                        r_gvalid  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_valid = r_mvalid;
    assign m_axis_data  = r_mdata;
    assign m_axis_last  = r_mlast;
    assign grant_valid  = r_gvalid;
    assign grant_id     = r_gid;
    assign pkt_count    = r_cnt;

endmodule

// File: doc/dma_stream_arbiter.md
Name: dma_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI4-Stream channel (into the DMA S2MM path) among NUM_SRC stream producers, for example loopback and compute-result streams.
- A grant is held from the first beat of a packet through the beat with last set; it is never re-arbitrated mid-packet.
- The output is registered through a one-entry pipeline stage that runs at full throughput.
- Status outputs report the current grant and a completed-packet counter for software and debug.

Parameters:
- NUM_SRC, 4, number of input streams (2..16).
- DATA_WIDTH, 32, stream data width in bits.
- CNT_WIDTH, 16, width of the completed-packet counter.
- IDW, derived as max(1, clog2(NUM_SRC)), width of the grant index (localparam).

Ports:
- axi_clk  in  1  clock.
- axi_reset_n  in  1  asynchronous, active-low reset.
- s_axis_valid  in  NUM_SRC  per-source valid.
- s_axis_data  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_last  in  NUM_SRC  per-source end-of-packet.
- s_axis_ready  out  NUM_SRC  per-source ready (combinational).
- m_axis_valid  out  1  output valid (registered).
- m_axis_data  out  DATA_WIDTH  output data (registered).
- m_axis_last  out  1  output end-of-packet (registered).
- m_axis_ready  in  1  downstream ready.
- grant_valid  out  1  high while a source holds the channel.
- grant_id  out  IDW  index of the granted source.
- pkt_count  out  CNT_WIDTH  number of packets fully accepted from sources (wraps).

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - state=IDLE, m_axis_valid=0, m_axis_data=0, m_axis_last=0.
  - grant_valid=0, grant_id=0, pkt_count=0.
  - rr_last=NUM_SRC-1, so source 0 has first priority.
- Reset mid-packet aborts the packet. m_axis_valid drops immediately and no partial beat is retained.
- FSM IDLE:
  - s_axis_ready=0.
  - If any s_axis_valid is set, select the first asserted source scanning rr_last+1, rr_last+2, ... modulo NUM_SRC.
  - Latch the winner into grant_id, set grant_valid, go to XFER.
  - This costs one arbitration bubble cycle per packet.
  - If no valid is set, stay in IDLE.
- FSM XFER:
  - s_axis_ready[grant_id] = out_free, where out_free = !m_axis_valid || m_axis_ready. All other ready bits are 0.
  - On accept (s_axis_valid[g] && s_axis_ready[g]), load m_axis_data/last from source g and set m_axis_valid=1.
  - If there is no accept and m_axis_ready=1, clear m_axis_valid and m_axis_last. If m_axis_ready=0, hold the output stable (AXI rule).
  - On an accepted beat with last=1:
    - rr_last<=grant_id, pkt_count<=pkt_count+1 (wraps modulo 2^CNT_WIDTH), grant_valid<=0, state<=IDLE.
    - The final beat may still sit in the output register; it drains normally while IDLE arbitrates.
- Latency: input accept to m_axis_valid is 1 cycle.
- Sustained rate within a packet is 1 beat/cycle while m_axis_ready=1.
- A one-beat packet (valid and last on the first beat) produces 2 cycles of occupancy: arbitration plus transfer.
- Simultaneous requests: exactly one winner per arbitration. A source that requested continuously is served within NUM_SRC packets (starvation-free).
- The granted source deasserting valid mid-packet keeps the grant; there is no timeout.
- Valid from non-granted sources has no effect and their ready stays 0.
- A source's valid dropping during IDLE before the decision cycle means that source is not selected.
- NUM_SRC not a power of two: the modulo scan skips nonexistent indices.

Decomposition:
- Shared package dma_pkg:
  - FSM state enum (ST_IDLE, ST_XFER).
  - Function for clog2-with-minimum-1.
  - Default DATA_WIDTH constant.
- One natural sub-module, rr_pick:
  - Combinational round-robin priority selector.
  - Inputs: request vector, rr_last. Outputs: any, winner index.
  - Reusable by later command-queue arbiters.

Test Plan:
- Reset then a single source: src0 sends 3 beats 0xA0,0xA1,0xA2 (last on 0xA2) with m_ready=1 → output identical sequence, 1-cycle latency, last on 0xA2, pkt_count=1, grant_id=0.
- Contention: src0..src3 all hold 2-beat packets continuously → grant order 0,1,2,3,0; beats never interleave; pkt_count=5 after five packets.
- Backpressure: m_ready toggled 1,0,0,1 during a src2 4-beat packet → m_axis_data/last stable while stalled, no beat lost or duplicated, s_axis_ready[2] low while the output is full and not drained.
- Stall and skip:
  - Source stall: granted src1 drops valid for 3 cycles mid-packet while src3 is valid → grant stays 1, src3 ready=0, src1 completes first.
  - Skip: after src1 completes, with rr_last=1 and only src0 requesting → src0 is granted (wrap-around skip).
- Counter wrap: with CNT_WIDTH=4, run 17 one-beat packets → pkt_count reads 1.
- Async reset asserted mid-packet (beat 2 of 5, m_ready=0) → m_axis_valid=0 and grant_valid=0 immediately; after release src0 has priority and a fresh packet passes intact.
